// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Purpose: round-robin arbiter that shares the ROB's single writeback port
// among N_REQ functional units (ALU, branch, LSU, MUL/DIV). Each requester
// owns a one-entry holding slot, so a unit can retire its result and move on
// without waiting for the grant. A packet presented while the ROB is stalling
// stays locked on the port until it is consumed. A pipeline flush discards
// every buffered result.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   req_valid     per-FU: a result is offered this cycle
//   req_ready     per-FU: the holding slot can take a result this cycle
//   req_pkt       per-FU writeback packet
//   flush_valid   pipeline nuke; empties all slots, blocks accept/present
//   wb_valid      a packet is presented to the ROB
//   wb_ready      ROB accepts the presented packet
//   wb_pkt        presented packet (don't-care while wb_valid is 0)
//   wb_grant_idx  requester index of wb_pkt (debug / perf counters)
// ---------------------------------------------------------------------------
package wb_arbiter_pkg;

  typedef struct packed {
    logic [5:0]  rob_idx;
    logic        epoch;
    logic [31:0] result;
  } fu_wb_t;

endpackage

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  fu_wb_t           req_pkt [N_REQ],
  input  logic             flush_valid,
  output logic             wb_valid,
  input  logic             wb_ready,
  output fu_wb_t           wb_pkt,
  output logic [IDX_W-1:0] wb_grant_idx
);

  logic [N_REQ-1:0] slot_valid_reg;
  logic [N_REQ-1:0] slot_valid_next;
  fu_wb_t           slot_pkt_reg [N_REQ];

  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;
  logic             lock_valid_reg;
  logic             lock_valid_next;
  logic [IDX_W-1:0] lock_idx_reg;
  logic [IDX_W-1:0] lock_idx_next;

  logic [IDX_W-1:0] grant;
  logic             wb_fire;
  logic [N_REQ-1:0] drain;
  logic [N_REQ-1:0] req_fire;

  // Grant selection. A locked grant wins outright so a stalled packet never
  // changes. Otherwise scan from rr_ptr upward with wrap; walking the offsets
  // from high to low makes the lowest offset (first in round-robin order)
  // the last assignment and therefore the winner.
  int scan_idx;

  always_comb begin
    grant    = rr_ptr_reg;
    scan_idx = 0;
    if (lock_valid_reg) begin
      grant = lock_idx_reg;
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        scan_idx = int'(rr_ptr_reg) + k;
        if (scan_idx >= N_REQ) begin
          scan_idx = scan_idx - N_REQ;
        end
        if (slot_valid_reg[scan_idx]) begin
          grant = IDX_W'(scan_idx);
        end
      end
    end
  end

  assign wb_valid     = ~flush_valid & (|slot_valid_reg);
  assign wb_fire      = wb_valid & wb_ready;
  assign wb_pkt       = slot_pkt_reg[grant];
  assign wb_grant_idx = grant;

  // Per-slot handshake. A slot being drained this cycle may be reloaded in
  // the same cycle, which is what lets one FU sustain a packet per cycle.
  // Flush dominates both accept and drain.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign drain[gi]     = wb_fire & (grant == IDX_W'(gi));
      assign req_ready[gi] = ~flush_valid & (~slot_valid_reg[gi] | drain[gi]);
      assign req_fire[gi]  = req_valid[gi] & req_ready[gi];

      always_comb begin
        slot_valid_next[gi] = slot_valid_reg[gi];
        if (flush_valid) begin
          slot_valid_next[gi] = 1'b0;
        end else if (req_fire[gi]) begin
          slot_valid_next[gi] = 1'b1;
        end else if (drain[gi]) begin
          slot_valid_next[gi] = 1'b0;
        end
      end
    end
  endgenerate

  // Lock and round-robin pointer. The lock captures whatever grant was shown
  // during a stalled cycle; wb_valid is already 0 under flush, so no fire or
  // lock-set can race with it.
  always_comb begin
    lock_valid_next = lock_valid_reg;
    lock_idx_next   = lock_idx_reg;
    rr_ptr_next     = rr_ptr_reg;
    if (flush_valid) begin
      lock_valid_next = 1'b0;
      rr_ptr_next     = '0;
    end else if (wb_fire) begin
      lock_valid_next = 1'b0;
      rr_ptr_next     = (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    end else if (wb_valid) begin
      lock_valid_next = 1'b1;
      lock_idx_next   = grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_reg <= '0;
      rr_ptr_reg     <= '0;
      lock_valid_reg <= 1'b0;
      lock_idx_reg   <= '0;
    end else begin
      slot_valid_reg <= slot_valid_next;
      rr_ptr_reg     <= rr_ptr_next;
      lock_valid_reg <= lock_valid_next;
      lock_idx_reg   <= lock_idx_next;
    end
  end

  // Packet storage needs no reset: contents are only observed while the
  // matching slot_valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (req_fire[i]) begin
        slot_pkt_reg[i] <= req_pkt[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//
// Purpose: directed, table-driven bench for wb_arbiter (N_REQ=4). Each table
// row is one clock cycle: inputs driven just after the rising edge, outputs
// compared on the falling edge. Hand-written sequences cover reset and an
// asynchronous reset taken mid-cycle with all slots full and the lock set.
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N = 4;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  fu_wb_t           req_pkt [N];
  logic             flush_valid;
  logic             wb_valid;
  logic             wb_ready;
  fu_wb_t           wb_pkt;
  logic [1:0]       wb_grant_idx;

  wb_arbiter #(.N_REQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_pkt      (req_pkt),
    .flush_valid  (flush_valid),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_pkt       (wb_pkt),
    .wb_grant_idx (wb_grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      rv;
    logic [3:0][5:0] rob;
    logic            flush;
    logic            wbr;
    logic            ev;
    logic [1:0]      eg;
    logic [5:0]      erob;
    logic [3:0]      erdy;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic fu_wb_t make_pkt(input logic [5:0] rob);
    fu_wb_t p;
    p.rob_idx = rob;
    p.epoch   = rob[0];
    p.result  = {rob, rob, rob, rob, 8'hA5};
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [3:0] rv,
                     input logic [5:0] r0, input logic [5:0] r1,
                     input logic [5:0] r2, input logic [5:0] r3,
                     input logic fl, input logic wbr,
                     input logic ev, input logic [1:0] eg, input logic [5:0] erob,
                     input logic [3:0] erdy);
    vec_t v;
    v.rv    = rv;
    v.rob   = {r3, r2, r1, r0};
    v.flush = fl;
    v.wbr   = wbr;
    v.ev    = ev;
    v.eg    = eg;
    v.erob  = erob;
    v.erdy  = erdy;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] rv, input logic [3:0][5:0] rob,
                       input logic fl, input logic wbr);
    req_valid   = rv;
    flush_valid = fl;
    wb_ready    = wbr;
    for (int i = 0; i < N; i++) begin
      req_pkt[i] = make_pkt(rob[i]);
    end
  endtask

  initial begin
    logic [3:0][5:0] robs;

    // ---------------- vector table ----------------
    // Single request from FU2
    add(4'b0100, 0, 0, 5, 0, 0, 1, 0, 0, 0, 4'b1111);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 1, 2, 5, 4'b1111);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1111);
    // Flush with rr_ptr=3 resets the pointer to 0
    add(4'b0000, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4'b0000);
    // All four fill; FU0 refilled at c2, FU3 held until its drain+reload
    add(4'b1111, 10, 11, 12, 13, 0, 1, 0, 0, 0, 4'b1111);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 1, 0, 10, 4'b0001);
    add(4'b1001, 20, 0, 0, 23, 0, 1, 1, 1, 11, 4'b0011);
    add(4'b1000, 0, 0, 0, 23, 0, 1, 1, 2, 12, 4'b0110);
    add(4'b1000, 0, 0, 0, 23, 0, 1, 1, 3, 13, 4'b1110);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 1, 0, 20, 4'b0111);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 1, 3, 23, 4'b1111);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1111);
    // Backpressure: FU1 locked while FU0 fills behind it
    add(4'b0010, 0, 31, 0, 0, 0, 1, 0, 0, 0, 4'b1111);
    add(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1, 31, 4'b1101);
    add(4'b0001, 30, 0, 0, 0, 0, 0, 1, 1, 31, 4'b1101);
    add(4'b0000, 0, 0, 0, 0, 0, 0, 1, 1, 31, 4'b1100);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 1, 1, 31, 4'b1110);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 1, 0, 30, 4'b1111);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1111);
    // Back-to-back FU3 for 8 cycles
    add(4'b1000, 0, 0, 0, 40, 0, 1, 0, 0, 0, 4'b1111);
    for (int k = 1; k < 8; k++) begin
      add(4'b1000, 0, 0, 0, 6'(40 + k), 0, 1, 1, 3, 6'(39 + k), 4'b1111);
    end
    add(4'b0000, 0, 0, 0, 0, 0, 1, 1, 3, 47, 4'b1111);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1111);
    // Flush with slots 0,2 full and FU1 requesting in the flush cycle
    add(4'b0101, 50, 0, 52, 0, 0, 0, 0, 0, 0, 4'b1111);
    add(4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 50, 4'b1010);
    add(4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 50, 4'b1010);
    add(4'b0010, 0, 51, 0, 0, 1, 1, 0, 0, 0, 4'b0000);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1111);
    add(4'b1010, 0, 54, 0, 55, 0, 1, 0, 0, 0, 4'b1111);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 1, 1, 54, 4'b0111);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 1, 3, 55, 4'b1111);
    add(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1111);

    // ---------------- reset ----------------
    rst_n = 1'b0;
    robs  = '0;
    drive(4'b0000, robs, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset wb_valid", 64'(wb_valid), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'hF);
    chk("reset grant_idx", 64'(wb_grant_idx), 64'd0);
    rst_n = 1'b1;

    // ---------------- table ----------------
    foreach (vecs[r]) begin
      @(posedge clk);
      #1;
      drive(vecs[r].rv, vecs[r].rob, vecs[r].flush, vecs[r].wbr);
      @(negedge clk);
      $display("row %0d: rv=%b fl=%b wbr=%b -> wb_valid=%b grant=%0d rob=%0d req_ready=%b",
               r, vecs[r].rv, vecs[r].flush, vecs[r].wbr, wb_valid, wb_grant_idx,
               wb_pkt.rob_idx, req_ready);
      chk($sformatf("row%0d wb_valid", r), 64'(wb_valid), 64'(vecs[r].ev));
      chk($sformatf("row%0d req_ready", r), 64'(req_ready), 64'(vecs[r].erdy));
      if (vecs[r].ev) begin
        chk($sformatf("row%0d grant_idx", r), 64'(wb_grant_idx), 64'(vecs[r].eg));
        chk($sformatf("row%0d wb_pkt", r), 64'(wb_pkt), 64'(make_pkt(vecs[r].erob)));
      end
    end

    // ---------------- async reset with full slots and lock set ----------------
    @(posedge clk);
    #1;
    robs = {6'd63, 6'd62, 6'd61, 6'd60};
    drive(4'b1111, robs, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(4'b0000, robs, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre-reset wb_valid", 64'(wb_valid), 64'd1);
    chk("pre-reset req_ready", 64'(req_ready), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: wb_valid=%b req_ready=%b", wb_valid, req_ready);
    chk("async wb_valid", 64'(wb_valid), 64'd0);
    chk("async req_ready", 64'(req_ready), 64'hF);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, robs, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    $display("post reset: wb_valid=%b req_ready=%b grant=%0d", wb_valid, req_ready, wb_grant_idx);
    chk("post-reset wb_valid", 64'(wb_valid), 64'd0);
    chk("post-reset req_ready", 64'(req_ready), 64'hF);
    chk("post-reset grant_idx", 64'(wb_grant_idx), 64'd0);
    // One fresh transaction after reset; stale locked packets must be gone
    @(posedge clk);
    #1;
    robs = {6'd0, 6'd7, 6'd0, 6'd0};
    drive(4'b0100, robs, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(4'b0000, robs, 1'b0, 1'b1);
    @(negedge clk);
    $display("post reset txn: wb_valid=%b grant=%0d rob=%0d", wb_valid, wb_grant_idx, wb_pkt.rob_idx);
    chk("post-reset txn valid", 64'(wb_valid), 64'd1);
    chk("post-reset txn grant", 64'(wb_grant_idx), 64'd2);
    chk("post-reset txn pkt", 64'(wb_pkt), 64'(make_pkt(6'd7)));
    @(posedge clk);
    @(negedge clk);
    chk("post-reset txn drained", 64'(wb_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
